// File: rtl/wowa_pkg.sv
// Shared constants and types for the wowa playback path.
package wowa_pkg;

    // DAC code for the analog midpoint; used as the idle / silent level.
    localparam logic [7:0] DAC_MIDSCALE = 8'h80;

    // Playback controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } player_state_t;

endpackage

// File: rtl/wowa_dac_player_if.sv
// Sample stream handshake into the DAC player.
interface wowa_dac_player_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/wowa_sample_fifo.sv
// Small synchronous FIFO buffering samples ahead of the DAC.
// Storage is not reset; only pointers and occupancy are.
module wowa_sample_fifo #(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Sample storage write; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo the depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wowa_dac_player.sv
// Playback side of the wowa front end: buffers handshaked samples and
// presents them to the R-2R DAC at a programmable rate, with priming
// and underrun handling.
module wowa_dac_player
    import wowa_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DIV_W      = 12,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    wowa_dac_player_if.slave    sif,
    input  logic [DIV_W-1:0]    rate_div,
    input  logic                hold_on_underrun,
    input  logic                clear_underrun,
    output logic [DATA_W-1:0]   dac_set,
    output logic                dac_strobe,
    output logic                underrun,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                playing
);

    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    // Terminal count for the divider; a period of 0 behaves like 1.
    function automatic logic [DIV_W-1:0] div_limit(input logic [DIV_W-1:0] rd);
        return (rd == '0) ? '0 : rd - DIV_W'(1);
    endfunction

    player_state_t     state;
    player_state_t     state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_lim;
    logic              tick;
    logic              do_pop;
    logic              do_underrun;
    logic              push;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;

    assign sif.sample_ready = !full;
    assign push             = sif.sample_valid && !full;

    wowa_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sif.sample_in),
        .pop       (do_pop),
        .head      (head),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: disable always wins; PRIME waits for a half-full buffer.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!empty) state_nxt = PRIME;
                PRIME:   if (fifo_level >= LVL_W'(FIFO_DEPTH / 2)) state_nxt = PLAY;
                PLAY:    if (do_underrun) state_nxt = PRIME;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: sample tick and what it does to the FIFO.
    always_comb begin
        playing     = (state == PLAY);
        tick        = (state == PLAY) && enable && (div_cnt == div_lim);
        do_pop      = tick && !empty;
        do_underrun = tick && empty;
    end

    // Rate divider; the period is re-latched at PLAY entry and on every wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            div_lim <= '0;
        end else if (state != PLAY) begin
            div_cnt <= '0;
            div_lim <= div_limit(rate_div);
        end else if (tick) begin
            div_cnt <= '0;
            div_lim <= div_limit(rate_div);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // DAC code register, strobe and sticky underrun (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_set    <= MIDSCALE;
            dac_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            dac_strobe <= do_pop;
            if (!enable) begin
                dac_set <= MIDSCALE;
            end else if (do_pop) begin
                dac_set <= head;
            end else if (do_underrun && !hold_on_underrun) begin
                dac_set <= MIDSCALE;
            end
            if (do_underrun) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wowa_dac_player.sv
// Directed testbench for wowa_dac_player: a cycle table for the basic
// playback/underrun trace plus hand-written multi-cycle sequences.
module tb_wowa_dac_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [11:0] rate_div;
    logic        hold_on_underrun;
    logic        clear_underrun;
    logic [7:0]  dac_set;
    logic        dac_strobe;
    logic        underrun;
    logic [2:0]  fifo_level;
    logic        playing;

    int tests = 0;
    int fails = 0;

    wowa_dac_player_if #(.DATA_W(8)) sif ();

    wowa_dac_player #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .DIV_W      (12)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .sif              (sif),
        .rate_div         (rate_div),
        .hold_on_underrun (hold_on_underrun),
        .clear_underrun   (clear_underrun),
        .dac_set          (dac_set),
        .dac_strobe       (dac_strobe),
        .underrun         (underrun),
        .fifo_level       (fifo_level),
        .playing          (playing)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit         en;
        bit         v;
        logic [7:0] d;
        bit         clr;
        logic [7:0] dac;
        bit         st;
        bit         ur;
        logic [2:0] lvl;
        bit         play;
        bit         rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input bit en, input bit v, input logic [7:0] d,
                       input bit clr, input logic [7:0] dac, input bit st, input bit ur,
                       input logic [2:0] lvl, input bit play, input bit rdy);
        vec_t r;
        r.en = en; r.v = v; r.d = d; r.clr = clr; r.dac = dac; r.st = st;
        r.ur = ur; r.lvl = lvl; r.play = play; r.rdy = rdy;
        for (int k = 0; k < n; k++) tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int max, input string name);
        int n = 0;
        while (!dac_strobe && n < max) begin
            cyc();
            n++;
        end
        tests++;
        if (!dac_strobe) begin
            fails++;
            $display("FAIL %s: got no strobe within %0d cycles, required a strobe", name, max);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        sif.sample_valid = 1'b0;
        sif.sample_in = 8'h00;
        clear_underrun = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        logic [7:0] s [4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int k = 0; k < 4; k++) begin
            sif.sample_valid = 1'b1;
            sif.sample_in = s[k];
            cyc();
        end
        sif.sample_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        rate_div = 12'd4;
        hold_on_underrun = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_dac", 32'(dac_set), 32'h80);
        chk("rst_ready", 32'(sif.sample_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_strobe", 32'(dac_strobe), 32'd0);

        // Pre-load in IDLE, prime, play at rate 4, underrun to midscale, clear.
        //  n  en v  d      clr dac    st ur lvl play rdy
        add(1, 0, 1, 8'h10, 0, 8'h80, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h20, 0, 8'h80, 0, 0, 1, 0, 1);
        add(1, 0, 1, 8'h30, 0, 8'h80, 0, 0, 2, 0, 1);
        add(1, 0, 1, 8'h40, 0, 8'h80, 0, 0, 3, 0, 1);
        add(1, 1, 0, 8'h00, 0, 8'h80, 0, 0, 4, 0, 0);
        add(1, 1, 0, 8'h00, 0, 8'h80, 0, 0, 4, 0, 0);
        add(4, 1, 0, 8'h00, 0, 8'h80, 0, 0, 4, 1, 0);
        add(1, 1, 0, 8'h00, 0, 8'h10, 1, 0, 3, 1, 1);
        add(3, 1, 0, 8'h00, 0, 8'h10, 0, 0, 3, 1, 1);
        add(1, 1, 0, 8'h00, 0, 8'h20, 1, 0, 2, 1, 1);
        add(3, 1, 0, 8'h00, 0, 8'h20, 0, 0, 2, 1, 1);
        add(1, 1, 0, 8'h00, 0, 8'h30, 1, 0, 1, 1, 1);
        add(3, 1, 0, 8'h00, 0, 8'h30, 0, 0, 1, 1, 1);
        add(1, 1, 0, 8'h00, 0, 8'h40, 1, 0, 0, 1, 1);
        add(3, 1, 0, 8'h00, 0, 8'h40, 0, 0, 0, 1, 1);
        add(1, 1, 0, 8'h00, 0, 8'h80, 0, 1, 0, 0, 1);
        add(1, 1, 0, 8'h00, 1, 8'h80, 0, 1, 0, 0, 1);
        add(1, 1, 0, 8'h00, 0, 8'h80, 0, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            enable = tbl[i].en;
            sif.sample_valid = tbl[i].v;
            sif.sample_in = tbl[i].d;
            clear_underrun = tbl[i].clr;
            chk($sformatf("tbl%0d_dac", i), 32'(dac_set), 32'(tbl[i].dac));
            chk($sformatf("tbl%0d_strobe", i), 32'(dac_strobe), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_underrun", i), 32'(underrun), 32'(tbl[i].ur));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_playing", i), 32'(playing), 32'(tbl[i].play));
            chk($sformatf("tbl%0d_ready", i), 32'(sif.sample_ready), 32'(tbl[i].rdy));
            cyc();
        end
        clear_underrun = 1'b0;

        // Underrun with hold: last code stays on the DAC.
        do_reset();
        hold_on_underrun = 1'b1;
        push4(8'h10, 8'h20, 8'h30, 8'h40);
        enable = 1'b1;
        for (int n = 0; n < 60 && !underrun; n++) cyc();
        chk("hold_underrun_set", 32'(underrun), 32'd1);
        chk("hold_dac", 32'(dac_set), 32'h40);
        chk("hold_playing", 32'(playing), 32'd0);
        hold_on_underrun = 1'b0;

        // Full FIFO back-pressure: 5th sample waits for the first pop.
        do_reset();
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        sif.sample_valid = 1'b1;
        sif.sample_in = 8'h55;
        for (int k = 0; k < 3; k++) begin
            chk("full_ready", 32'(sif.sample_ready), 32'd0);
            chk("full_level", 32'(fifo_level), 32'd4);
            cyc();
        end
        enable = 1'b1;
        for (int n = 0; n < 20 && !sif.sample_ready; n++) begin
            chk("full_level_wait", 32'(fifo_level), 32'd4);
            cyc();
        end
        chk("full_first_pop_dac", 32'(dac_set), 32'h11);
        chk("full_first_pop_level", 32'(fifo_level), 32'd3);
        cyc();
        sif.sample_valid = 1'b0;
        chk("full_refill_level", 32'(fifo_level), 32'd4);
        chk("full_refill_ready", 32'(sif.sample_ready), 32'd0);
        exp_seq[0] = 8'h22; exp_seq[1] = 8'h33; exp_seq[2] = 8'h44; exp_seq[3] = 8'h55;
        for (int k = 0; k < 4; k++) begin
            cyc();
            wait_strobe(10, "full_drain_strobe");
            chk($sformatf("full_drain%0d_dac", k), 32'(dac_set), 32'(exp_seq[k]));
        end

        // rate_div = 0: one sample per cycle.
        do_reset();
        rate_div = 12'd0;
        push4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        enable = 1'b1;
        wait_strobe(10, "fast_first_strobe");
        chk("fast_dac0", 32'(dac_set), 32'hA1);
        exp_seq[0] = 8'hA2; exp_seq[1] = 8'hA3; exp_seq[2] = 8'hA4;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("fast_strobe%0d", k + 1), 32'(dac_strobe), 32'd1);
            chk($sformatf("fast_dac%0d", k + 1), 32'(dac_set), 32'(exp_seq[k]));
        end
        cyc();
        chk("fast_after_strobe", 32'(dac_strobe), 32'd0);
        chk("fast_underrun", 32'(underrun), 32'd1);
        chk("fast_underrun_dac", 32'(dac_set), 32'h80);

        // Disable mid-PLAY, re-enable, then reset mid-PLAY.
        do_reset();
        rate_div = 12'd4;
        push4(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        enable = 1'b1;
        wait_strobe(20, "dis_strobe1");
        chk("dis_dac1", 32'(dac_set), 32'hB1);
        cyc();
        wait_strobe(10, "dis_strobe2");
        chk("dis_dac2", 32'(dac_set), 32'hB2);
        chk("dis_level_before", 32'(fifo_level), 32'd2);
        enable = 1'b0;
        cyc();
        chk("dis_playing", 32'(playing), 32'd0);
        chk("dis_dac", 32'(dac_set), 32'h80);
        chk("dis_level", 32'(fifo_level), 32'd2);
        enable = 1'b1;
        cyc();
        chk("reen_prime", 32'(playing), 32'd0);
        cyc();
        chk("reen_play", 32'(playing), 32'd1);
        wait_strobe(10, "reen_strobe");
        chk("reen_dac", 32'(dac_set), 32'hB3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_dac", 32'(dac_set), 32'h80);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_playing", 32'(playing), 32'd0);
        chk("midrst_ready", 32'(sif.sample_ready), 32'd1);
        chk("midrst_strobe", 32'(dac_strobe), 32'd0);
        chk("midrst_underrun", 32'(underrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
